// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: AXI4 instruction fetcher with an in-order tag FIFO for
// outstanding reads and a small instruction queue feeding the core.
// Optional feature macro: INST_FETCH_JMP_PREDECODE_EN. When defined, a fetched
// I_JMP redirects the fetch PC to its embedded target without flushing the
// instruction queue.
module inst_fetch_queue #(
    parameter int CRAM_ADDR_W     = 16,
    parameter int ADDR_W          = CRAM_ADDR_W,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IQ_DEPTH        = 4,
    parameter int PC_STEP         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [3:0]        s_cram_arid,
    output logic [31:0]       s_cram_araddr,
    output logic [7:0]        s_cram_arlen,
    output logic [2:0]        s_cram_arsize,
    output logic [1:0]        s_cram_arburst,
    output logic              s_cram_arlock,
    output logic [3:0]        s_cram_arcache,
    output logic [2:0]        s_cram_arprot,
    output logic [3:0]        s_cram_arqos,
    output logic              s_cram_arvalid,
    input  logic              s_cram_arready,
    output logic              s_cram_rready,
    input  logic [3:0]        s_cram_rid,
    input  logic [DATA_W-1:0] s_cram_rdata,
    input  logic [1:0]        s_cram_rresp,
    input  logic              s_cram_rlast,
    input  logic              s_cram_rvalid,
    output logic              o_inst_valid,
    output logic [DATA_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    input  logic              i_inst_ready,
    output logic              o_fetch_err
);

    localparam int TPW = $clog2(MAX_OUTSTANDING);
    localparam int QPW = $clog2(IQ_DEPTH);
    localparam logic [31:0] MAX_OUT_U  = MAX_OUTSTANDING;
    localparam logic [31:0] IQ_DEPTH_U = IQ_DEPTH;

`ifdef INST_FETCH_JMP_PREDECODE_EN
    localparam int INSTR_W = 8;
    localparam logic [INSTR_W-1:0] I_JMP = 8'hEA;
`endif

    // Fetch PC and a redirect target parked while an AR is stalled
    logic [ADDR_W-1:0] fpc, fpc_next;
    logic              pend_valid, pend_valid_next;
    logic [ADDR_W-1:0] pend_pc, pend_pc_next;

    // Tag FIFO: one entry per accepted-but-unreturned read
    logic [ADDR_W-1:0]          tag_pc [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] tag_kill;
    logic [TPW-1:0]             tag_wr, tag_rd;
    logic [TPW:0]               out_cnt;

    // Instruction queue towards the core
    logic [DATA_W-1:0] iq_data [IQ_DEPTH];
    logic [ADDR_W-1:0] iq_pc   [IQ_DEPTH];
    logic [QPW-1:0]    iq_wr, iq_rd;
    logic [QPW:0]      iq_cnt;

    logic [31:0]       out_cnt_w, iq_cnt_w;
    logic              credit_ok, ar_fire, tag_empty, r_fire, head_kill;
    logic              keep, iq_pop, jmp_hit, redir_any, push_kill;
    logic [ADDR_W-1:0] head_pc, redir_pc;
    logic              unused_ok;

    assign s_cram_arid    = 4'd0;
    assign s_cram_arlen   = 8'd0;
    assign s_cram_arsize  = 3'd2;
    assign s_cram_arburst = 2'd1;
    assign s_cram_arlock  = 1'b0;
    assign s_cram_arcache = 4'd0;
    assign s_cram_arprot  = 3'd0;
    assign s_cram_arqos   = 4'd0;
    assign s_cram_rready  = 1'b1;
    assign s_cram_araddr  = 32'(fpc);
    assign unused_ok      = ^{s_cram_rid, s_cram_rlast};

    assign out_cnt_w = 32'(out_cnt);
    assign iq_cnt_w  = 32'(iq_cnt);

    // A request is only offered when its response is guaranteed a queue slot;
    // while stalled, counts can only fall, so arvalid stays up until accepted.
    always_comb begin
        credit_ok = (out_cnt_w < MAX_OUT_U) && ((out_cnt_w + iq_cnt_w) < IQ_DEPTH_U);
    end

    assign s_cram_arvalid = credit_ok & ~rst;
    assign ar_fire        = s_cram_arvalid & s_cram_arready;
    assign tag_empty      = (out_cnt == '0);
    assign r_fire         = s_cram_rvalid & ~tag_empty;
    assign head_kill      = tag_kill[tag_rd];
    assign head_pc        = tag_pc[tag_rd];
    assign keep           = r_fire & ~head_kill & ~redirect_valid;
    assign iq_pop         = o_inst_valid & i_inst_ready;

    // Redirect source selection: an external redirect beats a predecoded jump
    always_comb begin
`ifdef INST_FETCH_JMP_PREDECODE_EN
        jmp_hit  = keep && (s_cram_rdata[DATA_W-1 -: INSTR_W] == I_JMP);
        redir_pc = redirect_valid ? redirect_pc : s_cram_rdata[ADDR_W-1:0];
`else
        jmp_hit  = 1'b0;
        redir_pc = redirect_pc;
`endif
        redir_any = redirect_valid | jmp_hit;
        push_kill = redir_any | pend_valid;
    end

    // Next fetch PC: step on accept, jump on redirect, park target while stalled
    always_comb begin
        fpc_next        = fpc;
        pend_valid_next = pend_valid;
        pend_pc_next    = pend_pc;
        if (ar_fire) begin
            if (redir_any) begin
                fpc_next = redir_pc;
            end else if (pend_valid) begin
                fpc_next = pend_pc;
            end else begin
                fpc_next = fpc + ADDR_W'(PC_STEP);
            end
            pend_valid_next = 1'b0;
        end else if (s_cram_arvalid) begin
            if (redir_any) begin
                pend_valid_next = 1'b1;
                pend_pc_next    = redir_pc;
            end
        end else begin
            if (redir_any) begin
                fpc_next = redir_pc;
            end else if (pend_valid) begin
                fpc_next = pend_pc;
            end
            pend_valid_next = 1'b0;
        end
    end

    // Fetch PC and pending redirect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc        <= '0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            fpc        <= fpc_next;
            pend_valid <= pend_valid_next;
            pend_pc    <= pend_pc_next;
        end
    end

    // Tag FIFO control; any redirect marks every in-flight read as stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr   <= '0;
            tag_rd   <= '0;
            out_cnt  <= '0;
            tag_kill <= '0;
        end else begin
            if (ar_fire) begin
                tag_wr <= tag_wr + TPW'(1);
            end
            if (r_fire) begin
                tag_rd <= tag_rd + TPW'(1);
            end
            out_cnt <= out_cnt + {{TPW{1'b0}}, ar_fire} - {{TPW{1'b0}}, r_fire};
            if (redir_any) begin
                tag_kill <= '1;
            end
            if (ar_fire) begin
                tag_kill[tag_wr] <= push_kill;
            end
        end
    end

    // Tag FIFO storage: PC of each accepted request
    always_ff @(posedge clk) begin
        if (ar_fire) begin
            tag_pc[tag_wr] <= fpc;
        end
    end

    // Instruction queue control; an external redirect empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iq_wr  <= '0;
            iq_rd  <= '0;
            iq_cnt <= '0;
        end else if (redirect_valid) begin
            iq_rd  <= iq_wr;
            iq_cnt <= '0;
        end else begin
            if (keep) begin
                iq_wr <= iq_wr + QPW'(1);
            end
            if (iq_pop) begin
                iq_rd <= iq_rd + QPW'(1);
            end
            iq_cnt <= iq_cnt + {{QPW{1'b0}}, keep} - {{QPW{1'b0}}, iq_pop};
        end
    end

    // Instruction queue storage
    always_ff @(posedge clk) begin
        if (keep) begin
            iq_data[iq_wr] <= s_cram_rdata;
            iq_pc[iq_wr]   <= head_pc;
        end
    end

    // Sticky error: orphan response or error on a kept response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_fetch_err <= 1'b0;
        end else if ((s_cram_rvalid & tag_empty) | (keep & (s_cram_rresp != 2'd0))) begin
            o_fetch_err <= 1'b1;
        end
    end

    assign o_inst_valid = (iq_cnt != '0);
    assign o_inst       = o_inst_valid ? iq_data[iq_rd] : '0;
    assign o_inst_pc    = o_inst_valid ? iq_pc[iq_rd] : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: randomized AXI slave and core, with the
// expected architectural instruction stream kept in a scoreboard queue.
module tb_inst_fetch_queue;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam logic [7:0] I_JMP = 8'hEA;

    logic              clk;
    logic              rst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [3:0]        s_cram_arid;
    logic [31:0]       s_cram_araddr;
    logic [7:0]        s_cram_arlen;
    logic [2:0]        s_cram_arsize;
    logic [1:0]        s_cram_arburst;
    logic              s_cram_arlock;
    logic [3:0]        s_cram_arcache;
    logic [2:0]        s_cram_arprot;
    logic [3:0]        s_cram_arqos;
    logic              s_cram_arvalid;
    logic              s_cram_arready;
    logic              s_cram_rready;
    logic [3:0]        s_cram_rid;
    logic [DATA_W-1:0] s_cram_rdata;
    logic [1:0]        s_cram_rresp;
    logic              s_cram_rlast;
    logic              s_cram_rvalid;
    logic              o_inst_valid;
    logic [DATA_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_inst_pc;
    logic              i_inst_ready;
    logic              o_fetch_err;

    inst_fetch_queue #(
        .CRAM_ADDR_W(ADDR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_OUTSTANDING(4), .IQ_DEPTH(4), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .s_cram_arid(s_cram_arid), .s_cram_araddr(s_cram_araddr),
        .s_cram_arlen(s_cram_arlen), .s_cram_arsize(s_cram_arsize),
        .s_cram_arburst(s_cram_arburst), .s_cram_arlock(s_cram_arlock),
        .s_cram_arcache(s_cram_arcache), .s_cram_arprot(s_cram_arprot),
        .s_cram_arqos(s_cram_arqos), .s_cram_arvalid(s_cram_arvalid),
        .s_cram_arready(s_cram_arready), .s_cram_rready(s_cram_rready),
        .s_cram_rid(s_cram_rid), .s_cram_rdata(s_cram_rdata),
        .s_cram_rresp(s_cram_rresp), .s_cram_rlast(s_cram_rlast),
        .s_cram_rvalid(s_cram_rvalid),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_inst_ready(i_inst_ready), .o_fetch_err(o_fetch_err)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        logic [1:0]  resp;
    } rsp_t;

    int n_vec = 0;
    int n_err = 0;

    rsp_t              slave_q[$];
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] next_pc;
    logic [31:0]       ar_log[$];

    int ar_pct, rdy_pct, redir_pct, lat_min, lat_max;
    int cycle, ar_count, deliveries, bubbles;
    bit jmp_mode, err_armed, exp_err, spurious, force_redir;
    bit track_bubbles, started, prev_stall;
    logic [ADDR_W-1:0] err_pc, force_pc;
    logic [31:0]       prev_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents as a pure function of the word address
    function automatic logic [31:0] memval(logic [ADDR_W-1:0] pc);
        if (jmp_mode && pc == 16'h0004) begin
            return {I_JMP, 24'h000200};
        end
        return {8'h13, 8'h00, pc ^ 16'hA5A5};
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 16) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 16'd4;
        end
    endtask

    task automatic refill(logic [ADDR_W-1:0] start);
        exp_q.delete();
        next_pc = start;
        topup();
    endtask

    task automatic configure(int ap, int rp, int dp, int lmin, int lmax);
        ar_pct = ap; rdy_pct = rp; redir_pct = dp; lat_min = lmin; lat_max = lmax;
    endtask

    // One bus cycle, entered at the falling edge: drive, observe, update model
    task automatic applyStimulus();
        rsp_t r;
        cycle++;
        s_cram_arready = ($urandom_range(99) < ar_pct);
        i_inst_ready   = ($urandom_range(99) < rdy_pct);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(99) < redir_pct);
            redirect_pc    = ADDR_W'($urandom_range(255) << 2);
        end
        if (spurious) begin
            s_cram_rvalid = 1'b1;
            s_cram_rdata  = 32'hDEADBEEF;
            s_cram_rresp  = 2'd0;
            spurious      = 1'b0;
        end else if (slave_q.size() > 0 && slave_q[0].due <= cycle) begin
            r = slave_q.pop_front();
            s_cram_rvalid = 1'b1;
            s_cram_rdata  = memval(r.addr[ADDR_W-1:0]);
            s_cram_rresp  = r.resp;
        end else begin
            s_cram_rvalid = 1'b0;
            s_cram_rdata  = $urandom;
            s_cram_rresp  = 2'd0;
        end
        #1;
        if (prev_stall) begin
            checkOutput("ar_hold_valid", 32'(s_cram_arvalid), 32'd1);
            checkOutput("ar_hold_addr", s_cram_araddr, prev_addr);
        end
        if (s_cram_arvalid && s_cram_arready) begin
            r.addr = s_cram_araddr;
            r.due  = cycle + $urandom_range(lat_max, lat_min);
            r.resp = (err_armed && s_cram_araddr == 32'(err_pc)) ? 2'd2 : 2'd0;
            slave_q.push_back(r);
            ar_count++;
            ar_log.push_back(s_cram_araddr);
        end
        prev_stall = s_cram_arvalid && !s_cram_arready;
        prev_addr  = s_cram_araddr;
        #2;
        if (redirect_valid) begin
            refill(redirect_pc);
        end else begin
            topup();
        end
    endtask

    task automatic runCycles(int n);
        repeat (n) begin
            @(negedge clk);
            applyStimulus();
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        s_cram_arready = 1'b0; s_cram_rvalid = 1'b0; s_cram_rdata = '0; s_cram_rresp = 2'd0;
        redirect_valid = 1'b0; redirect_pc = '0; i_inst_ready = 1'b0;
        slave_q.delete();
        prev_stall = 1'b0; spurious = 1'b0; force_redir = 1'b0;
        #1;
        checkOutput("rst_arvalid", 32'(s_cram_arvalid), 32'd0);
        checkOutput("rst_inst_valid", 32'(o_inst_valid), 32'd0);
        checkOutput("rst_inst", o_inst, 32'd0);
        checkOutput("rst_inst_pc", 32'(o_inst_pc), 32'd0);
        checkOutput("rst_fetch_err", 32'(o_fetch_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        jmp_mode = 1'b0; err_armed = 1'b0; exp_err = 1'b0;
        ar_count = 0; ar_log.delete(); deliveries = 0; bubbles = 0; started = 1'b0;
        refill('0);
        #1;
        checkOutput("post_rst_arvalid", 32'(s_cram_arvalid), 32'd1);
        checkOutput("post_rst_araddr", s_cram_araddr, 32'd0);
        prev_stall = 1'b1;
        prev_addr  = 32'd0;
    endtask

    // Monitor: pops the expected stream on every core handshake
    initial begin
        logic [ADDR_W-1:0] pc;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (track_bubbles) begin
                    if (started && !o_inst_valid) bubbles++;
                    if (o_inst_valid) started = 1'b1;
                end
                if (o_inst_valid && i_inst_ready) begin
                    deliveries++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("[TB] FAIL stream_empty: got pc 0x%0h, expected no delivery", o_inst_pc);
                    end else begin
                        pc = exp_q.pop_front();
                        if (err_armed && pc == err_pc) exp_err = 1'b1;
                        checkOutput("inst_pc", 32'(o_inst_pc), 32'(pc));
                        checkOutput("inst_data", o_inst, memval(pc));
                        checkOutput("fetch_err", 32'(o_fetch_err), 32'(exp_err));
                    end
                end
            end
        end
    end

    initial begin
        int d0;
        rst = 1'b1; cycle = 0; track_bubbles = 1'b0;
        s_cram_rid = 4'd0; s_cram_rlast = 1'b1;
        configure(0, 0, 0, 1, 1);

        // Streaming: full throughput, sequential addresses, no bubbles
        doReset();
        configure(100, 100, 0, 1, 1);
        track_bubbles = 1'b1;
        runCycles(30);
        track_bubbles = 1'b0;
        checkOutput("stream_ar_count", 32'(ar_log.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < ar_log.size(); i++) begin
            checkOutput("stream_araddr", ar_log[i], 32'(i * 4));
        end
        checkOutput("stream_bubbles", 32'(bubbles), 32'd0);
        checkOutput("stream_count", 32'(deliveries >= 20), 32'd1);

        // Back-pressure: exactly four requests, then resume in order
        doReset();
        configure(100, 0, 0, 1, 1);
        runCycles(12);
        checkOutput("bp_ar_count", 32'(ar_count), 32'd4);
        checkOutput("bp_arvalid_low", 32'(s_cram_arvalid), 32'd0);
        configure(100, 100, 0, 1, 1);
        runCycles(20);
        checkOutput("bp_resume", 32'(deliveries >= 10), 32'd1);

        // Redirect with reads in flight
        doReset();
        configure(100, 100, 0, 3, 3);
        runCycles(6);
        force_redir = 1'b1; force_pc = 16'h0100;
        runCycles(25);
        checkOutput("redir_progress", 32'(deliveries >= 5), 32'd1);

        // Redirect while the address channel is stalled
        doReset();
        configure(0, 100, 0, 1, 1);
        runCycles(2);
        force_redir = 1'b1; force_pc = 16'h0040;
        runCycles(3);
        configure(100, 100, 0, 1, 1);
        runCycles(20);
        checkOutput("stall_ar_log_size", 32'(ar_log.size() >= 2), 32'd1);
        if (ar_log.size() >= 2) begin
            checkOutput("stall_first_addr", ar_log[0], 32'h0);
            checkOutput("stall_second_addr", ar_log[1], 32'h40);
        end

        // Error response on pc 0x8: delivered and sticky
        doReset();
        err_armed = 1'b1; err_pc = 16'h0008;
        configure(100, 100, 0, 1, 1);
        runCycles(15);
        checkOutput("err_sticky", 32'(o_fetch_err), 32'd1);

        // Jump word at pc 0x4 targeting 0x200
        doReset();
        jmp_mode = 1'b1;
`ifdef INST_FETCH_JMP_PREDECODE_EN
        exp_q.delete();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0004);
        next_pc = 16'h0200;
        topup();
`endif
        configure(100, 100, 0, 1, 1);
        runCycles(20);
        checkOutput("jmp_progress", 32'(deliveries >= 10), 32'd1);

        // Response with nothing outstanding
        doReset();
        configure(0, 100, 0, 1, 1);
        spurious = 1'b1;
        runCycles(3);
        checkOutput("orphan_err", 32'(o_fetch_err), 32'd1);
        checkOutput("orphan_no_inst", 32'(o_inst_valid), 32'd0);

        // Randomized traffic, then a drain phase proving forward progress
        doReset();
        configure(70, 60, 3, 1, 4);
        runCycles(2000);
        configure(100, 100, 0, 1, 1);
        d0 = deliveries;
        runCycles(40);
        checkOutput("drain_progress", 32'(deliveries - d0 >= 20), 32'd1);
        checkOutput("rand_fetch_err", 32'(o_fetch_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
